// File: rtl/video_mode_sequencer_if.sv
// Bundle of the mode-sequencer request/ack and status signals.
// master = the sequencer itself, slave = the downstream consumer / stimulus side.
interface video_mode_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3
);
    logic [DATA_W-1:0] data_in;
    logic              change_ack;
    logic [IDX_W-1:0]  mode_index;
    logic [IDX_W-1:0]  pending_index;
    logic              change_req;
    logic              busy;
    logic              invalid_code;
    logic              timeout_err;

    modport master (
        input  data_in, change_ack,
        output mode_index, pending_index, change_req, busy, invalid_code, timeout_err
    );

    modport slave (
        output data_in, change_ack,
        input  mode_index, pending_index, change_req, busy, invalid_code, timeout_err
    );
endinterface

// File: rtl/video_mode_sequencer.sv
// Debounces a mode-select code, decodes it against a code table and runs a request/ack/holdoff
// handshake. Define VIDEO_MODE_ACK_TIMEOUT_EN to give up on an unacknowledged request.
module video_mode_sequencer #(
    parameter int                            DATA_W         = 8,
    parameter int                            NUM_MODES      = 5,
    parameter logic [NUM_MODES*DATA_W-1:0]   MODE_CODES     = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
    parameter int                            DEFAULT_MODE   = 0,
    parameter int                            STABLE_CYCLES  = 16,
    parameter int                            HOLDOFF_CYCLES = 64,
    parameter int                            TIMEOUT_CYCLES = 1024
) (
    input logic                     clock,
    input logic                     reset,
    video_mode_sequencer_if.master  bus
);
    localparam int IDX_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int SC_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int HO_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [HO_W-1:0]  HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MODE);

    typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_HOLDOFF} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [SC_W-1:0]   stable_cnt_q, stable_cnt_d;
    logic              evaluated_q, evaluated_d;
    logic [IDX_W-1:0]  mode_index_q, mode_index_d;
    logic [IDX_W-1:0]  pending_index_q, pending_index_d;
    logic              change_req_q, change_req_d;
    logic              busy_q, busy_d;
    logic              invalid_code_q, invalid_code_d;
    logic [HO_W-1:0]   holdoff_cnt_q, holdoff_cnt_d;
`ifdef VIDEO_MODE_ACK_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]   timeout_cnt_q, timeout_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    logic              input_changed;
    logic              settled;
    logic [NUM_MODES-1:0] code_hit;
    logic              dec_valid;
    logic [IDX_W-1:0]  dec_idx;

    // Table lookup runs on the registered sample; it equals data_in whenever a value is settled.
    for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_decode
        assign code_hit[gi] = (MODE_CODES[gi*DATA_W +: DATA_W] == data_in_q);
    end

    always_comb begin
        dec_idx = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (code_hit[i]) dec_idx = IDX_W'(i);
        end
    end

    assign dec_valid     = |code_hit;
    assign input_changed = (bus.data_in != data_in_q);
    assign settled       = !input_changed && (stable_cnt_q == SC_LAST);

    always_comb begin
        state_d         = state_q;
        data_in_d       = bus.data_in;
        stable_cnt_d    = stable_cnt_q;
        evaluated_d     = evaluated_q;
        mode_index_d    = mode_index_q;
        pending_index_d = pending_index_q;
        change_req_d    = change_req_q;
        invalid_code_d  = 1'b0;
        holdoff_cnt_d   = holdoff_cnt_q;
`ifdef VIDEO_MODE_ACK_TIMEOUT_EN
        timeout_cnt_d   = timeout_cnt_q;
        timeout_err_d   = 1'b0;
`endif

        if (input_changed) begin
            stable_cnt_d = '0;
            evaluated_d  = 1'b0;
        end else if (stable_cnt_q != SC_LAST) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (settled && !evaluated_q) begin
                    evaluated_d = 1'b1;
                    if (!dec_valid) begin
                        invalid_code_d = 1'b1;
                    end else if (dec_idx != mode_index_q) begin
                        pending_index_d = dec_idx;
                        change_req_d    = 1'b1;
                        state_d         = ST_REQUEST;
`ifdef VIDEO_MODE_ACK_TIMEOUT_EN
                        timeout_cnt_d   = '0;
`endif
                    end
                end
            end
            ST_REQUEST: begin
                // An ack arriving on the timeout cycle still completes the change.
                if (bus.change_ack) begin
                    mode_index_d  = pending_index_q;
                    change_req_d  = 1'b0;
                    holdoff_cnt_d = '0;
                    state_d       = ST_HOLDOFF;
                end
`ifdef VIDEO_MODE_ACK_TIMEOUT_EN
                else if (timeout_cnt_q == TO_LAST) begin
                    change_req_d  = 1'b0;
                    timeout_err_d = 1'b1;
                    holdoff_cnt_d = '0;
                    state_d       = ST_HOLDOFF;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                end
`endif
            end
            ST_HOLDOFF: begin
                if (holdoff_cnt_q == HO_LAST) state_d = ST_IDLE;
                else holdoff_cnt_d = holdoff_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            data_in_q       <= '0;
            stable_cnt_q    <= '0;
            evaluated_q     <= 1'b0;
            mode_index_q    <= DEF_IDX;
            pending_index_q <= DEF_IDX;
            change_req_q    <= 1'b0;
            busy_q          <= 1'b0;
            invalid_code_q  <= 1'b0;
            holdoff_cnt_q   <= '0;
`ifdef VIDEO_MODE_ACK_TIMEOUT_EN
            timeout_cnt_q   <= '0;
            timeout_err_q   <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            data_in_q       <= data_in_d;
            stable_cnt_q    <= stable_cnt_d;
            evaluated_q     <= evaluated_d;
            mode_index_q    <= mode_index_d;
            pending_index_q <= pending_index_d;
            change_req_q    <= change_req_d;
            busy_q          <= busy_d;
            invalid_code_q  <= invalid_code_d;
            holdoff_cnt_q   <= holdoff_cnt_d;
`ifdef VIDEO_MODE_ACK_TIMEOUT_EN
            timeout_cnt_q   <= timeout_cnt_d;
            timeout_err_q   <= timeout_err_d;
`endif
        end
    end

    assign bus.mode_index    = mode_index_q;
    assign bus.pending_index = pending_index_q;
    assign bus.change_req    = change_req_q;
    assign bus.busy          = busy_q;
    assign bus.invalid_code  = invalid_code_q;
`ifdef VIDEO_MODE_ACK_TIMEOUT_EN
    assign bus.timeout_err   = timeout_err_q;
`else
    assign bus.timeout_err   = 1'b0;
`endif
endmodule

// File: tb/tb_video_mode_sequencer.sv
// Self-checking bench for video_mode_sequencer: directed scenarios plus random stimulus,
// all outputs compared every cycle against a run-length based behavioural model.
module tb_video_mode_sequencer;
    localparam int STABLE = 16;
    localparam int HOLD   = 64;
    localparam int TO     = 8;
`ifdef VIDEO_MODE_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    video_mode_sequencer_if #(.DATA_W(8), .IDX_W(3)) vif ();

    video_mode_sequencer #(
        .DATA_W(8), .NUM_MODES(5), .MODE_CODES({8'h05, 8'h04, 8'h03, 8'h02, 8'h01}),
        .DEFAULT_MODE(0), .STABLE_CYCLES(STABLE), .HOLDOFF_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(vif.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned codes [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    function automatic int lookup(input logic [7:0] v);
        for (int i = 0; i < 5; i++) if (codes[i] == v) return i;
        return -1;
    endfunction

    bit         m_valid = 0;
    logic [7:0] m_run_val;
    int         m_run_len, m_req_age, m_hold_left, m_mode, m_pending;
    bit         m_eval, m_requesting, m_inv, m_to;

    always @(posedge clock) begin
        int idx;
        cycle++;
        if (reset) begin
            m_valid = 1; m_run_val = 8'h00; m_run_len = 1; m_eval = 0;
            m_requesting = 0; m_hold_left = 0; m_mode = 0; m_pending = 0;
            m_inv = 0; m_to = 0; m_req_age = 0;
        end else if (m_valid) begin
            m_inv = 0; m_to = 0;
            if (vif.data_in != m_run_val) begin
                m_run_val = vif.data_in; m_run_len = 1; m_eval = 0;
            end else if (m_run_len < 100000) begin
                m_run_len++;
            end
            if (m_requesting) begin
                if (vif.change_ack) begin
                    m_mode = m_pending; m_requesting = 0; m_hold_left = HOLD;
                end else begin
                    m_req_age++;
                    if (TO_EN && m_req_age >= TO) begin
                        m_to = 1; m_requesting = 0; m_hold_left = HOLD;
                    end
                end
            end else if (m_hold_left > 0) begin
                m_hold_left--;
            end else if (m_run_len >= STABLE + 1 && !m_eval) begin
                m_eval = 1;
                idx = lookup(m_run_val);
                if (idx < 0) m_inv = 1;
                else if (idx != m_mode) begin
                    m_pending = idx; m_requesting = 1; m_req_age = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("mode_index", int'(vif.mode_index), m_mode);
            chk("pending_index", int'(vif.pending_index), m_pending);
            chk("change_req", int'(vif.change_req), int'(m_requesting));
            chk("busy", int'(vif.busy), int'(m_requesting || m_hold_left > 0));
            chk("invalid_code", int'(vif.invalid_code), int'(m_inv));
            chk("timeout_err", int'(vif.timeout_err), int'(m_to));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_req(input string name, input int limit, output int n);
        n = 0;
        while (!vif.change_req && n < limit) begin
            cyc();
            n++;
        end
        chk(name, int'(vif.change_req), 1);
    endtask

    task automatic ack_once();
        vif.change_ack = 1'b1;
        cyc();
        vif.change_ack = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (vif.busy && n < 300) begin
            cyc();
            n++;
        end
        chk(name, int'(vif.busy), 0);
    endtask

    initial begin
        int n, any_req, any_inv, cnt;
        logic [7:0] pick [8];
        pick = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF, 8'h03};
        vif.data_in = 8'h01;
        vif.change_ack = 1'b0;
        reset = 1'b1;
        repeat (3) cyc();
        chk("rst_mode", int'(vif.mode_index), 0);
        chk("rst_req", int'(vif.change_req), 0);
        chk("rst_busy", int'(vif.busy), 0);
        reset = 1'b0;

        // Default-mode code settles: nothing happens.
        any_req = 0; any_inv = 0;
        repeat (20) begin
            cyc();
            any_req |= int'(vif.change_req);
            any_inv |= int'(vif.invalid_code);
        end
        chk("r033_no_req", any_req, 0);
        chk("r033_no_inv", any_inv, 0);
        chk("r033_mode", int'(vif.mode_index), 0);

        // 01 -> 03: request after edge E16, ack 5 cycles later, 64-cycle holdoff.
        vif.data_in = 8'h03;
        wait_req("r034_req_seen", 40, n);
        chk("r034_latency_edges", n - 1, 16);
        chk("r034_pending", int'(vif.pending_index), 2);
        repeat (4) cyc();
        chk("r034_pending_stable", int'(vif.pending_index), 2);
        ack_once();
        chk("r034_mode", int'(vif.mode_index), 2);
        chk("r034_req_drop", int'(vif.change_req), 0);
        cnt = int'(vif.busy);
        n = 0;
        while (n < 200) begin
            cyc();
            n++;
            if (vif.busy) cnt++;
            else break;
        end
        chk("r034_busy_cycles", cnt, 64);

        // Unknown code: one invalid pulse, mode unchanged.
        vif.data_in = 8'hFF;
        cnt = 0;
        repeat (40) begin
            cyc();
            cnt += int'(vif.invalid_code);
        end
        chk("r036_inv_pulses", cnt, 1);
        chk("r036_mode", int'(vif.mode_index), 2);

        // Toggling input never settles; then 04 held gives index 3.
        any_req = 0;
        for (int i = 0; i < 6; i++) begin
            vif.data_in = (i % 2 == 0) ? 8'h03 : 8'h04;
            repeat (10) begin
                cyc();
                any_req |= int'(vif.change_req);
            end
        end
        chk("r035_no_req", any_req, 0);
        wait_req("r035_req_seen", 40, n);
        chk("r035_pending", int'(vif.pending_index), 3);
        ack_once();
        chk("r035_mode", int'(vif.mode_index), 3);
        wait_idle("r035_idle");

        // Input moves during a request: request unchanged, new value served after holdoff.
        vif.data_in = 8'h03;
        wait_req("r037_req_seen", 40, n);
        chk("r037_pending", int'(vif.pending_index), 2);
        vif.data_in = 8'h05;
        repeat (3) cyc();
        chk("r037_pending_held", int'(vif.pending_index), 2);
        ack_once();
        chk("r037_mode", int'(vif.mode_index), 2);
        wait_req("r037_req2_seen", 200, n);
        chk("r037_pending2", int'(vif.pending_index), 4);
        ack_once();
        chk("r037_mode2", int'(vif.mode_index), 4);
        wait_idle("r037_idle");

        // Unacknowledged request.
        vif.data_in = 8'h01;
        wait_req("noack_req_seen", 40, n);
        chk("noack_pending", int'(vif.pending_index), 0);
`ifdef VIDEO_MODE_ACK_TIMEOUT_EN
        cnt = 1; n = 0; any_inv = 0;
        while (n < 100) begin
            cyc();
            n++;
            any_inv += int'(vif.timeout_err);
            if (vif.change_req) cnt++;
            else break;
        end
        chk("r038_req_cycles", cnt, 8);
        any_req = 0;
        repeat (100) begin
            cyc();
            any_req |= int'(vif.change_req);
            any_inv += int'(vif.timeout_err);
        end
        chk("r038_to_pulses", any_inv, 1);
        chk("r038_no_retry", any_req, 0);
        chk("r038_mode", int'(vif.mode_index), 4);
        vif.data_in = 8'h02;
        wait_req("rst_mid_req_seen", 40, n);
`else
        any_inv = 0;
        repeat (40) begin
            cyc();
            any_inv |= int'(vif.timeout_err);
        end
        chk("r032_req_held", int'(vif.change_req), 1);
        chk("r032_no_timeout", any_inv, 0);
`endif
        // Reset while a request is outstanding.
        reset = 1'b1;
        cyc();
        chk("rst_mid_req_drop", int'(vif.change_req), 0);
        chk("rst_mid_mode", int'(vif.mode_index), 0);
        chk("rst_mid_pending", int'(vif.pending_index), 0);
        reset = 1'b0;

        // Random phase.
        cnt = 0;
        repeat (3000) begin
            if (cnt == 0) begin
                vif.data_in = pick[$urandom_range(0, 7)];
                cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 40);
            end
            cnt--;
            vif.change_ack = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 599) == 0);
            cyc();
        end
        reset = 1'b0;
        vif.change_ack = 1'b0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cycle);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/video_mode_sequencer.md
VIDEO_MODE_SEQUENCER -- requirements
Module: video_mode_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of mode-select code.
REQ-002 SHALL have parameter NUM_MODES, default 5, number of table entries (1..16).
REQ-003 SHALL have parameter MODE_CODES, default {8'h05,8'h04,8'h03,8'h02,8'h01}, packed NUM_MODES*DATA_W code table; entry i occupies bits [i*DATA_W +: DATA_W].
REQ-004 SHALL have parameter DEFAULT_MODE, default 0, mode index after reset.
REQ-005 SHALL have parameter STABLE_CYCLES, default 16 (>=1), input settle length.
REQ-006 SHALL have parameter HOLDOFF_CYCLES, default 64 (>=1), lockout after a change.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 1024, ack timeout (used only under REQ-031).
REQ-008 clock  in  1  sole clock, all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 data_in  in  DATA_W  requested mode code, asynchronous to meaning, may glitch.
REQ-011 change_ack  in  1  downstream accepts pending_index this cycle.
REQ-012 mode_index  out  IDX_W=$clog2(NUM_MODES) (min 1)  active mode.
REQ-013 pending_index  out  IDX_W  mode offered while change_req high.
REQ-014 change_req  out  1  mode change request, level, held until ack/timeout.
REQ-015 busy  out  1  high in REQUEST and HOLDOFF.
REQ-016 invalid_code  out  1  one-cycle pulse, settled code not in table.
REQ-017 timeout_err  out  1  one-cycle pulse, ack timeout.

Function
REQ-018 SHALL register data_in every cycle into data_in_reg; stable_cnt SHALL clear to 0 when data_in != data_in_reg, else increment, saturating at STABLE_CYCLES-1.
REQ-019 A value SHALL be "settled" when stable_cnt == STABLE_CYCLES-1 and data_in == data_in_reg; each distinct settled value SHALL be evaluated exactly once (evaluated flag cleared on any input change).
REQ-020 Decode SHALL return the lowest index i with MODE_CODES entry i == data_in; no match = invalid.
REQ-021 States: IDLE, REQUEST, HOLDOFF; evaluation SHALL occur only in IDLE.
REQ-022 IDLE, settled, unevaluated: invalid -> pulse invalid_code, stay IDLE; index == mode_index -> no action; else load pending_index, assert change_req, go REQUEST.
REQ-023 Latency: data_in held constant across edges E0..E_S (S=STABLE_CYCLES), new value first sampled at E0 -> change_req high after edge E_S.
REQ-024 REQUEST: change_ack sampled high -> mode_index <= pending_index and change_req low on the same edge, go HOLDOFF.
REQ-025 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles, then IDLE.
REQ-026 data_in changes during REQUEST/HOLDOFF SHALL NOT withdraw or alter the request; settling continues, and an unevaluated settled value SHALL be evaluated on the first IDLE cycle.
REQ-027 change_ack outside REQUEST SHALL be ignored.
REQ-028 pending_index SHALL be stable whenever change_req is high; mode_index SHALL change only per REQ-024.

Reset
REQ-029 On reset: state IDLE, mode_index=pending_index=DEFAULT_MODE, change_req=busy=invalid_code=timeout_err=0, data_in_reg=0, stable_cnt=0, evaluated=0, all counters 0; reset mid-REQUEST SHALL drop change_req on the next edge with mode_index=DEFAULT_MODE.

Configuration
REQ-030 Macro VIDEO_MODE_ACK_TIMEOUT_EN selects ack timeout.
REQ-031 Defined: after TIMEOUT_CYCLES cycles in REQUEST without ack, change_req drops, timeout_err pulses once, mode_index unchanged, go HOLDOFF; value stays evaluated (no retry until data_in changes); ack on the timeout cycle wins.
REQ-032 Undefined: REQUEST waits indefinitely; timeout_err tied 0; port still present.

Verification
REQ-033 Reset, data_in=8'h01 stable 20 cycles -> no change_req, mode_index=0, invalid_code never high.
REQ-034 data_in 8'h01->8'h03 held -> change_req high after E16, pending_index=2; ack 5 cycles later -> mode_index=2, busy high 64 more cycles.
REQ-035 data_in toggles 8'h03/8'h04 every 10 cycles -> change_req never asserts; then 8'h04 held -> request with pending_index=3.
REQ-036 data_in=8'hFF held 16+ cycles -> exactly one invalid_code pulse, mode_index unchanged.
REQ-037 During REQUEST for index 2, data_in->8'h05 and held; ack -> mode_index=2, then after HOLDOFF second request pending_index=4.
REQ-038 With VIDEO_MODE_ACK_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> change_req drops after 8 cycles, one timeout_err pulse, mode_index unchanged, no retry.
